// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction memory request/response bundle for fetch_ctrl
interface fetch_ctrl_if #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [WIDTH-1:0]  imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - single-outstanding instruction fetch FSM with redirect and stall handling
module fetch_ctrl #(
    parameter int WIDTH  = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    fetch_ctrl_if.master      mem,
    input  logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_next,
    output logic              pc_en,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] pc_inc;
    logic [1:0]       unused_rpc_lo;

    assign target        = {redirect_pc[WIDTH-1:2], 2'b00};
    assign unused_rpc_lo = redirect_pc[1:0];
    assign pc_inc        = pc + WIDTH'(4);

    // PC update is same-cycle so the PC register already holds the new value on the next request
    always_comb begin
        pc_en = 1'b0;
        case (state)
            REQ:           pc_en = redirect | mem.imem_ack;
            HOLD, DISCARD: pc_en = redirect;
            default:       pc_en = 1'b0;
        endcase
    end

    assign pc_next = !pc_en ? '0 : (redirect ? target : pc_inc);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            mem.imem_req  <= 1'b0;
            mem.imem_addr <= '0;
            inst          <= '0;
            inst_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state         <= REQ;
                    mem.imem_req  <= 1'b1;
                    mem.imem_addr <= '0;
                end
                REQ: begin
                    if (redirect) begin
                        // Without an ack the bus request must complete at its old address
                        if (mem.imem_ack) mem.imem_addr <= target;
                        else              state         <= DISCARD;
                    end else if (mem.imem_ack) begin
                        inst         <= mem.imem_rdata;
                        inst_valid   <= 1'b1;
                        mem.imem_req <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect || !stall) begin
                        inst_valid    <= 1'b0;
                        mem.imem_req  <= 1'b1;
                        mem.imem_addr <= redirect ? target : pc;
                        state         <= REQ;
                    end
                end
                DISCARD: begin
                    if (mem.imem_ack) begin
                        mem.imem_addr <= redirect ? target : pc;
                        state         <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc, pc_next, redirect_pc, inst;
    logic        pc_en, stall, redirect, inst_valid;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.WIDTH(32), .INST_W(32)) mif();

    fetch_ctrl #(.WIDTH(32), .INST_W(32)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem         (mif),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_valid  (inst_valid)
    );

    // Downstream PC register
    always @(posedge clk or negedge rstn) begin
        if (!rstn)      pc <= 32'h0;
        else if (pc_en) pc <= pc_next;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-order PC, whether an instruction is held,
    // and whether the outstanding request was abandoned by a redirect.
    bit          m_idle = 1'b1, m_held = 1'b0, m_stale = 1'b0;
    logic [31:0] m_stale_addr = 32'h0, m_pc = 32'h0;
    bit          n_idle = 1'b1, n_held = 1'b0, n_stale = 1'b0;
    logic [31:0] n_stale_addr = 32'h0, n_pc = 32'h0;
    bit          e_pc_en = 1'b0;
    logic [31:0] e_pc_next = 32'h0;
    logic [31:0] exp_q[$];

    task automatic step(input bit ack, input logic [31:0] rd, input bit st,
                        input bit rdr, input logic [31:0] tgt);
        logic [31:0] t;
        @(posedge clk);
        #1;
        m_idle = n_idle; m_held = n_held; m_stale = n_stale;
        m_stale_addr = n_stale_addr; m_pc = n_pc;
        ack = ack && !m_held;
        rdr = rdr && !m_idle;
        mif.imem_ack = ack; mif.imem_rdata = rd;
        stall = st; redirect = rdr; redirect_pc = tgt;
        t = tgt & ~32'h3;
        e_pc_en = 1'b0; e_pc_next = 32'h0;
        if (m_idle) begin
            n_idle = 1'b0;
        end else if (m_held) begin
            if (rdr) begin
                e_pc_en = 1'b1; e_pc_next = t; n_pc = t; n_held = 1'b0;
            end else if (!st) begin
                n_held = 1'b0;
            end
        end else if (rdr) begin
            e_pc_en = 1'b1; e_pc_next = t; n_pc = t;
            if (ack) n_stale = 1'b0;
            else if (!m_stale) begin
                n_stale = 1'b1; n_stale_addr = m_pc;
            end
        end else if (ack) begin
            if (m_stale) n_stale = 1'b0;
            else begin
                exp_q.push_back(rd);
                n_held = 1'b1; e_pc_en = 1'b1;
                e_pc_next = m_pc + 32'h4; n_pc = m_pc + 32'h4;
            end
        end
    endtask

    task automatic do_reset(input bit late_ack);
        @(posedge clk);
        #3;
        rstn = 1'b0; mif.imem_ack = 1'b0; redirect = 1'b0; stall = 1'b0;
        m_idle = 1'b1; m_held = 1'b0; m_stale = 1'b0; m_pc = 32'h0;
        e_pc_en = 1'b0; e_pc_next = 32'h0;
        exp_q.delete();
        #1;
        chk("rst_imem_req", 32'(mif.imem_req), 32'h0);
        chk("rst_imem_addr", mif.imem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc_en", 32'(pc_en), 32'h0);
        chk("rst_pc_next", pc_next, 32'h0);
        @(posedge clk);
        #3;
        rstn = 1'b1;
        mif.imem_ack = late_ack; mif.imem_rdata = 32'hBAD0_0BAD;
        n_idle = 1'b0; n_held = 1'b0; n_stale = 1'b0; n_pc = 32'h0;
    endtask

    always @(negedge clk) begin
        chk("imem_req", 32'(mif.imem_req), 32'(!m_idle && !m_held));
        if (m_idle || !m_held)
            chk("imem_addr", mif.imem_addr, m_idle ? 32'h0 : (m_stale ? m_stale_addr : m_pc));
        chk("pc_en", 32'(pc_en), 32'(e_pc_en));
        if (e_pc_en) chk("pc_next", pc_next, e_pc_next);
        chk("inst_valid", 32'(inst_valid), 32'(m_held));
        chk("pc", pc, m_pc);
    end

    logic        prev_v = 1'b0;
    logic [31:0] held_inst = 32'h0;

    always @(negedge clk) begin
        if (inst_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL inst_unexpected: got %h expected no instruction", inst);
            end else begin
                chk("inst", inst, exp_q.pop_front());
            end
            held_inst = inst;
        end else if (inst_valid) begin
            chk("inst_stable", inst, held_inst);
        end
        prev_v = inst_valid;
    end

    initial begin
        mif.imem_ack = 1'b0; mif.imem_rdata = 32'h0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        do_reset(1'b0);

        // First fetch: ack after 3 cycles, then consume and refetch at 4
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Stall held for 5 cycles
        step(1'b1, 32'h1111_2222, 1'b0, 1'b0, 32'h0);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Redirect without ack, stale ack discarded
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Redirect coinciding with ack
        step(1'b1, 32'h5555_AAAA, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // PC wrap
        step(1'b1, 32'h7777_7777, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset while discarding, late ack in IDLE
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
        do_reset(1'b1);
        step(1'b1, 32'hC0DE_0000, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        repeat (3000) begin
            if ($urandom_range(0, 199) == 0)
                do_reset(1'($urandom_range(0, 1)));
            else
                step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 7) == 0), $urandom);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, sets the address/PC width.
REQ-002 Parameter INST_W, default 32, sets the instruction width.
REQ-003 clk  input  1  system clock; all state updates on posedge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 pc  input  WIDTH  current PC; the q output of the downstream PC register, which resets to 0.
REQ-006 pc_next  output  WIDTH  d input of the PC register.
REQ-007 pc_en  output  1  en input of the PC register; one-cycle pulse per PC update.
REQ-008 imem_req  output  1  instruction memory request.
REQ-009 imem_addr  output  WIDTH  request address; registered.
REQ-010 imem_ack  input  1  memory accepts the request; data valid this cycle.
REQ-011 imem_rdata  input  INST_W  instruction data; sampled only when imem_ack=1.
REQ-012 stall  input  1  decode not ready; inst is not consumed while high.
REQ-013 redirect  input  1  branch/jump taken; single-cycle pulse.
REQ-014 redirect_pc  input  WIDTH  target address; bits [1:0] are ignored and forced to 0.
REQ-015 inst  output  INST_W  fetched instruction; registered.
REQ-016 inst_valid  output  1  inst holds an unconsumed instruction; registered.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, HOLD and DISCARD.
REQ-018 IDLE SHALL last exactly one cycle after reset release, with imem_req=0, and then go to REQ with imem_addr=0.
REQ-019 In REQ and DISCARD, imem_req SHALL be 1 and imem_addr SHALL stay constant until the cycle imem_ack=1.
REQ-020 In IDLE and HOLD, imem_req SHALL be 0.
REQ-021 REQ, imem_ack=1, redirect=0: inst<=imem_rdata, inst_valid<=1, pc_en=1, pc_next=pc+4, next state HOLD.
REQ-022 HOLD, redirect=0, stall=1: all outputs SHALL hold.
REQ-023 HOLD, redirect=0, stall=0: the instruction is consumed this cycle; inst_valid<=0, imem_addr<=pc, next state REQ.
REQ-024 Redirect in HOLD: inst_valid<=0, pc_en=1, pc_next=redirect_pc, imem_addr<=redirect_pc, next state REQ; redirect has priority over stall.
REQ-025 Redirect in REQ with imem_ack=1 in the same cycle: rdata is discarded and inst_valid stays 0.
REQ-026 Also in that case: pc_en=1, pc_next=redirect_pc, imem_addr<=redirect_pc, next state REQ.
REQ-027 Redirect in REQ with imem_ack=0: pc_en=1, pc_next=redirect_pc, next state DISCARD, and imem_addr keeps the abandoned address.
REQ-028 DISCARD with imem_ack=1: rdata is discarded, imem_addr<=pc, next state REQ.
REQ-029 A redirect in DISCARD SHALL update the PC as in REQ-027.
REQ-030 If that redirect coincides with imem_ack=1, imem_addr<=redirect_pc and next state is REQ; otherwise the FSM stays in DISCARD.
REQ-031 pc_en SHALL be asserted at most once per cycle and only in the cycles listed in REQ-021, REQ-024, REQ-026, REQ-027 and REQ-029.
REQ-032 pc_next SHALL equal pc+4 whenever pc_en=1 and no redirect is taken.
REQ-033 pc+4 SHALL wrap modulo 2^WIDTH, so 0xFFFFFFFC -> 0x00000000.
REQ-034 inst SHALL change only on a REQ-021 capture and SHALL never be driven from DISCARD data.
REQ-035 stall SHALL have no effect in IDLE, REQ or DISCARD.

Reset
REQ-036 On rstn=0, state, inst_valid and inst SHALL be 0 immediately, without waiting for clk.
REQ-037 During reset, imem_req=0, imem_addr=0, pc_en=0 and pc_next=0.
REQ-038 Reset mid-transaction (REQ/DISCARD) SHALL abandon the request; an imem_ack arriving after release while in IDLE is ignored.
REQ-039 After release, fetch SHALL restart per REQ-018.

Verification
REQ-040 Reset release, ack after 3 cycles, rdata=0x00000013, stall=0 -> imem_addr=0; inst=0x13 with inst_valid=1 one cycle after ack; pc_en pulse with pc_next=4; next request at addr 4.
REQ-041 stall=1 for 5 cycles in HOLD -> inst and inst_valid stable, imem_req=0; then stall=0 -> inst_valid=0 next cycle, request at pc.
REQ-042 Redirect to 0x00000103 in REQ, ack 2 cycles later with 0xDEADBEEF -> pc_next=0x100; imem_addr keeps the old address until ack; 0xDEADBEEF never appears on inst; next request at 0x100.
REQ-043 Redirect to 0x40 in the same cycle as ack -> inst_valid stays 0; imem_addr=0x40 next cycle.
REQ-044 pc=0xFFFFFFFC, ack -> pc_next=0x00000000.
REQ-045 rstn low for 1 cycle while in DISCARD -> outputs 0 asynchronously; a late ack in IDLE is ignored; first request after release is at addr 0.
